// File: rtl/md_sched_if.sv
// EX-stage multiply/divide sequencer port bundle.
// The master side is the pipeline, and the slave side is md_sched.
interface md_sched_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        DISABLE;
  logic        md_in_D;
  logic        busy;
  logic        need_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B, DISABLE, md_in_D,
    input  busy, need_stall, HI, LO
  );

  modport slave (
    input  start, op, A, B, DISABLE, md_in_D,
    output busy, need_stall, HI, LO
  );
endinterface

// File: rtl/md_sched.sv
// md_sched: multi-cycle MULT/DIV sequencer owning HI/LO; MADD/MSUB family is built only with MD_MADD_EN.
// Busy for MULT_CYCLES/DIV_CYCLES after accept; starts while busy or flushed are dropped; need_stall holds D.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  md_if
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        op_legal;
  logic        op_is_div;
  logic        op_is_mt;
  logic        accept;
  logic        accept_multi;
  logic [CW-1:0] cnt_load;

  always_comb begin
    op_legal  = 1'b0;
    op_is_div = 1'b0;
    op_is_mt  = 1'b0;
    case (md_if.op)
      OP_MULT, OP_MULTU: op_legal = 1'b1;
      OP_DIV, OP_DIVU: begin
        op_legal  = 1'b1;
        op_is_div = 1'b1;
      end
      OP_MTHI, OP_MTLO: begin
        op_legal = 1'b1;
        op_is_mt = 1'b1;
      end
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_legal = 1'b1;
`endif
      default: ;
    endcase
  end

  assign accept       = md_if.start & ~md_if.DISABLE & ~busy_q & op_legal;
  assign accept_multi = accept & ~op_is_mt;
  assign cnt_load     = op_is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);

  // Result datapath works only on latched operands, so it is a stable multi-cycle path during RUN.
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0] quo_u, rem_u;
  logic        div_ovf;
  logic [63:0] hilo_d;

  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign a_zx   = {32'h0, a_q};
  assign b_zx   = {32'h0, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign quo_s   = (b_q == 32'h0 || div_ovf) ? 32'sh0 : $signed(a_q) / $signed(b_q);
  assign rem_s   = (b_q == 32'h0 || div_ovf) ? 32'sh0 : $signed(a_q) % $signed(b_q);
  assign quo_u   = (b_q == 32'h0) ? 32'h0 : a_q / b_q;
  assign rem_u   = (b_q == 32'h0) ? 32'h0 : a_q % b_q;

  always_comb begin
    hilo_d = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  hilo_d = prod_s;
      OP_MULTU: hilo_d = prod_u;
      OP_DIV: begin
        if (div_ovf)
          hilo_d = {32'h0, 32'h8000_0000};
        else if (b_q != 32'h0)
          hilo_d = {rem_s, quo_s};
      end
      OP_DIVU: begin
        if (b_q != 32'h0)
          hilo_d = {rem_u, quo_u};
      end
`ifdef MD_MADD_EN
      OP_MADD:  hilo_d = {hi_q, lo_q} + prod_s;
      OP_MADDU: hilo_d = {hi_q, lo_q} + prod_u;
      OP_MSUB:  hilo_d = {hi_q, lo_q} - prod_s;
      OP_MSUBU: hilo_d = {hi_q, lo_q} - prod_u;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      op_q    <= 4'h0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (md_if.op == OP_MTHI) begin
              hi_q <= md_if.A;
            end else if (md_if.op == OP_MTLO) begin
              lo_q <= md_if.A;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= cnt_load;
              op_q    <= md_if.op;
              a_q     <= md_if.A;
              b_q     <= md_if.B;
            end
          end
        end
        RUN: begin
          // DISABLE is deliberately ignored here: the running op has already retired.
          if (cnt_q == '0) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            {hi_q, lo_q} <= hilo_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md_if.busy       = busy_q;
  assign md_if.need_stall = md_if.md_in_D & (busy_q | accept_multi);
  assign md_if.HI         = hi_q;
  assign md_if.LO         = lo_q;

  a_busy_is_run: assert property (@(posedge clk) disable iff (!reset)
    busy_q == (state_q == RUN));
  a_idle_cnt_zero: assert property (@(posedge clk) disable iff (!reset)
    (state_q == IDLE) |-> (cnt_q == '0) || $past(state_q == IDLE));

endmodule

// File: tb/tb_md_sched.sv
// Randomized bench for md_sched against an arithmetic reference model of HI/LO and busy timing.
module tb_md_sched;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_sched_if bus ();

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_op;
  int          m_left;
  logic        last_busy, last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op >= 4'd1) && (op <= 4'd10);
`else
    return (op >= 4'd1) && (op <= 4'd6);
`endif
  endfunction

  function automatic bit multi(input logic [3:0] op);
    return legal(op) && op != 4'd5 && op != 4'd6;
  endfunction

  function automatic int latency(input logic [3:0] op);
    return (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
  endfunction

  // HI/LO after an op commits, computed with 64-bit integer arithmetic.
  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    res = acc;
    case (op)
      4'd1: res = sa * sb;
      4'd2: res = ua * ub;
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      4'd4: if (b != 0) begin q = ua / ub; r = ua % ub; res = {r[31:0], q[31:0]}; end
      4'd7: res = acc + sa * sb;
      4'd8: res = acc + ua * ub;
      4'd9: res = acc - sa * sb;
      4'd10: res = acc - ua * ub;
      default: ;
    endcase
    return res;
  endfunction

  task automatic step(input bit st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit dis, input bit mdd, input bit rst_n);
    bit acc;
    @(negedge clk);
    reset       = rst_n;
    bus.start   = st;
    bus.op      = op;
    bus.A       = a;
    bus.B       = b;
    bus.DISABLE = dis;
    bus.md_in_D = mdd;
    #1;
    acc = st && !dis && m_left == 0 && legal(op);
    check("busy", {31'h0, bus.busy}, {31'h0, m_left > 0});
    check("hi", bus.HI, m_hi);
    check("lo", bus.LO, m_lo);
    check("need_stall", {31'h0, bus.need_stall}, {31'h0, mdd && (m_left > 0 || (acc && multi(op)))});
    last_busy  = bus.busy;
    last_stall = bus.need_stall;
    @(posedge clk);
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = model_result(m_op, m_a, m_b, {m_hi, m_lo});
    end else if (acc) begin
      if (op == 4'd5) m_hi = a;
      else if (op == 4'd6) m_lo = a;
      else begin
        m_left = latency(op);
        m_op = op; m_a = a; m_b = b;
      end
    end
  endtask

  task automatic idle(input bit mdd);
    step(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, mdd, 1'b1);
  endtask

  task automatic wait_idle(input bit mdd, output int nb, output int ns);
    int guard;
    nb = 0; ns = 0; guard = 0;
    do begin
      idle(mdd);
      nb += int'(last_busy);
      ns += int'(last_stall);
      guard++;
    end while (last_busy && guard < 100);
    if (last_busy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic expect_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    #2;
    check({tag, "_hi"}, bus.HI, hi);
    check({tag, "_lo"}, bus.LO, lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb, ns, s0;
    bus.start = 0; bus.op = 0; bus.A = 0; bus.B = 0; bus.DISABLE = 0; bus.md_in_D = 1;
    m_hi = 0; m_lo = 0; m_left = 0; m_op = 0; m_a = 0; m_b = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", {31'h0, bus.busy}, 32'd0);
    check("rst_need_stall", {31'h0, bus.need_stall}, 32'd0);
    expect_hilo("rst", 32'h0, 32'h0);

    // MULT / MULTU with busy and stall lengths
    step(1, 4'd1, 32'hFFFF_FFFE, 32'd3, 0, 1, 1);
    s0 = int'(last_stall);
    wait_idle(1, nb, ns);
    check("mult_busy_cycles", nb, MULT_N);
    check("mult_stall_cycles", s0 + ns, MULT_N + 1);
    expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    step(1, 4'd2, 32'hFFFF_FFFE, 32'd3, 0, 0, 1);
    wait_idle(0, nb, ns);
    expect_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    // DIV / DIVU-by-zero
    step(1, 4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 1);
    wait_idle(0, nb, ns);
    check("div_busy_cycles", nb, DIV_N);
    expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    step(1, 4'd4, 32'd7, 32'd0, 0, 0, 1);
    wait_idle(0, nb, ns);
    check("divu0_busy_cycles", nb, DIV_N);
    expect_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // flushed start, then a second start while busy
    step(1, 4'd1, 32'd5, 32'd7, 1, 0, 1);
    idle(0);
    check("disable_busy", {31'h0, last_busy}, 32'd0);
    expect_hilo("disable", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    step(1, 4'd1, 32'd4, 32'd5, 0, 0, 1);
    step(1, 4'd1, 32'd9, 32'd9, 0, 0, 1);
    wait_idle(0, nb, ns);
    check("double_busy_cycles", nb, MULT_N - 1);
    repeat (3) idle(0);
    expect_hilo("double", 32'h0, 32'd20);

    // MTHI, signed-divide overflow case
    step(1, 4'd5, 32'h1234, 32'h0, 0, 1, 1);
    check("mthi_stall", {31'h0, last_stall}, 32'd0);
    expect_hilo("mthi", 32'h1234, 32'd20);
    check("mthi_busy", {31'h0, bus.busy}, 32'd0);
    step(1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1);
    wait_idle(0, nb, ns);
    expect_hilo("div_ovf", 32'h0, 32'h8000_0000);

    // reset in the 3rd busy cycle of a DIV
    step(1, 4'd3, 32'd100, 32'd7, 0, 0, 1);
    idle(0); idle(0);
    step(0, 4'd0, 32'h0, 32'h0, 0, 0, 0);
    expect_hilo("rst_mid", 32'h0, 32'h0);
    check("rst_mid_busy", {31'h0, bus.busy}, 32'd0);

`ifdef MD_MADD_EN
    step(1, 4'd6, 32'd5, 32'h0, 0, 0, 1);
    step(1, 4'd7, 32'd2, 32'd3, 0, 0, 1);
    wait_idle(0, nb, ns);
    expect_hilo("madd", 32'h0, 32'd11);
    step(1, 4'd10, 32'd1, 32'd12, 0, 0, 1);
    wait_idle(0, nb, ns);
    expect_hilo("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 199) != 0);
    end
    wait_idle(0, nb, ns);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
